// File: rtl/ula_pkg.sv
// Shared definitions for the sequential ULA: opcode constants, the
// controller state encoding and the BCD digit-count helper used to
// validate the DIGITS parameter at elaboration.
package ula_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_DIV = 3'b110;
  localparam logic [2:0] OP_NOP = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_CONV,
    ST_DONE
  } state_t;

  // Smallest d with 10^d > 2^(2*width): floor(2*width*log10(2)) + 1.
  function automatic int unsigned bcd_digits_for(input int unsigned width);
    return (2 * width * 30103) / 100000 + 1;
  endfunction

endpackage

// File: rtl/bcd_dabble_seq.sv
// Sequential double-dabble binary-to-BCD converter.
//   clk, rst : clock and synchronous active-high reset
//   load     : start a conversion of 'value'
//   value    : IN_W-bit unsigned binary input
//   busy     : conversion in progress
//   done     : high during the cycle whose rising edge completes the
//              conversion (bcd is updated on that same edge)
//   bcd      : DIGITS packed BCD digits, digit 0 in [3:0]; holds the
//              last completed conversion
// A conversion takes IN_W edges: the load edge performs the first shift.
module bcd_dabble_seq #(
  parameter int unsigned IN_W   = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [IN_W-1:0]       value,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int unsigned CNT_W = $clog2(IN_W) + 1;

  logic [IN_W-1:0]     sh_q;
  logic [4*DIGITS-1:0] acc_q;
  logic [4*DIGITS-1:0] acc_adj;
  logic [4*DIGITS-1:0] acc_next;
  logic [CNT_W-1:0]    cnt_q;

  always_comb begin
    acc_adj = acc_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
    acc_next = (acc_adj << 1) | {{(4*DIGITS-1){1'b0}}, sh_q[IN_W-1]};
  end

  assign done = busy && (cnt_q == CNT_W'(IN_W - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q  <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      busy  <= 1'b0;
      bcd   <= '0;
    end else if (load) begin
      // Accumulator starts at zero, so the first shift needs no adjust.
      sh_q  <= value << 1;
      acc_q <= (4*DIGITS)'(value[IN_W-1]);
      cnt_q <= CNT_W'(1);
      busy  <= 1'b1;
    end else if (busy) begin
      sh_q  <= sh_q << 1;
      acc_q <= acc_next;
      cnt_q <= cnt_q + 1'b1;
      if (done) begin
        bcd  <= acc_next;
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ula_seq_nbits.sv
// Multi-cycle WIDTH-bit ULA with start/ready/done handshake.
//   CLK, RST    : clock, synchronous active-high reset
//   A_in, B_in  : operands; Cin carry/borrow-in; OP_sel opcode
//   Start_in    : request, accepted only while Ready_out=1
//   Ready_out   : high in IDLE; Done_out one-cycle completion pulse
//   Result_out  : 2*WIDTH result; Rem_out division remainder
//   Cout, OV, Z, ERR, Neg_out : status flags
//   BCD_out     : decimal magnitude of the result, digit 0 in [3:0]
// Outputs change only on the edge entering DONE and hold until the next.
module ula_seq_nbits
  import ula_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [WIDTH-1:0]      A_in,
  input  logic [WIDTH-1:0]      B_in,
  input  logic                  Cin,
  input  logic [2:0]            OP_sel,
  input  logic                  Start_in,
  output logic                  Ready_out,
  output logic                  Done_out,
  output logic [2*WIDTH-1:0]    Result_out,
  output logic [WIDTH-1:0]      Rem_out,
  output logic                  Cout,
  output logic                  OV,
  output logic                  Z,
  output logic                  ERR,
  output logic                  Neg_out,
  output logic [4*DIGITS-1:0]   BCD_out
);

  if (WIDTH < 4) begin : g_width_check
    $error("ula_seq_nbits: WIDTH must be at least 4");
  end
  if (DIGITS < bcd_digits_for(WIDTH)) begin : g_digits_check
    $error("ula_seq_nbits: DIGITS too small to hold 2^(2*WIDTH)");
  end

  localparam int unsigned IT_W = $clog2(WIDTH) + 1;

  state_t               state;
  logic [WIDTH-1:0]     a_q, b_q, r_q, q_q;
  logic [2*WIDTH-1:0]   p_q, res_q;
  logic [WIDTH-1:0]     rem_q;
  logic                 cout_q, ov_q, err_q, neg_q, conv_load;
  logic [IT_W-1:0]      it_q;

  logic [WIDTH:0]       sum_w, dif_w, mul_t, div_sh, div_trial;
  logic [WIDTH-1:0]     s_res, r_next, q_next, neg_mag;
  logic                 s_cout, s_ov, s_neg;
  logic [2*WIDTH-1:0]   p_next, mag;
  logic                 dab_busy, dab_done;

  always_comb begin
    sum_w  = {1'b0, A_in} + {1'b0, B_in} + {{WIDTH{1'b0}}, Cin};
    dif_w  = {1'b0, A_in} - {1'b0, B_in} - {{WIDTH{1'b0}}, Cin};
    s_res  = '0;
    s_cout = 1'b0;
    s_ov   = 1'b0;
    s_neg  = 1'b0;
    case (OP_sel)
      OP_ADD: begin
        s_res  = sum_w[WIDTH-1:0];
        s_cout = sum_w[WIDTH];
        s_ov   = (A_in[WIDTH-1] == B_in[WIDTH-1]) && (sum_w[WIDTH-1] != A_in[WIDTH-1]);
      end
      OP_SUB: begin
        s_res  = dif_w[WIDTH-1:0];
        s_cout = dif_w[WIDTH];
        s_ov   = (A_in[WIDTH-1] != B_in[WIDTH-1]) && (dif_w[WIDTH-1] != A_in[WIDTH-1]);
        s_neg  = dif_w[WIDTH-1];
      end
      OP_AND:  s_res = A_in & B_in;
      OP_OR:   s_res = A_in | B_in;
      OP_XOR:  s_res = A_in ^ B_in;
      default: s_res = '0;
    endcase
  end

  // Shift-add: high half accumulates the multiplicand, low half holds the
  // remaining multiplier bits and fills with product bits from the top.
  always_comb begin
    mul_t  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, a_q} : '0);
    p_next = {mul_t, p_q[WIDTH-1:1]};
  end

  // Restoring division: keep the trial difference only when non-negative.
  always_comb begin
    div_sh    = {r_q, q_q[WIDTH-1]};
    div_trial = div_sh - {1'b0, b_q};
    if (!div_trial[WIDTH]) begin
      r_next = div_trial[WIDTH-1:0];
      q_next = {q_q[WIDTH-2:0], 1'b1};
    end else begin
      r_next = div_sh[WIDTH-1:0];
      q_next = {q_q[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    neg_mag = ~res_q[WIDTH-1:0] + 1'b1;
    mag     = neg_q ? {{WIDTH{1'b0}}, neg_mag} : res_q;
  end

  bcd_dabble_seq #(
    .IN_W   (2*WIDTH),
    .DIGITS (DIGITS)
  ) u_dabble (
    .clk   (CLK),
    .rst   (RST),
    .load  (conv_load),
    .value (mag),
    .busy  (dab_busy),
    .done  (dab_done),
    .bcd   (BCD_out)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      r_q        <= '0;
      q_q        <= '0;
      p_q        <= '0;
      res_q      <= '0;
      rem_q      <= '0;
      cout_q     <= 1'b0;
      ov_q       <= 1'b0;
      err_q      <= 1'b0;
      neg_q      <= 1'b0;
      conv_load  <= 1'b0;
      it_q       <= '0;
      Ready_out  <= 1'b1;
      Done_out   <= 1'b0;
      Result_out <= '0;
      Rem_out    <= '0;
      Cout       <= 1'b0;
      OV         <= 1'b0;
      Z          <= 1'b0;
      ERR        <= 1'b0;
      Neg_out    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Start_in) begin
            Ready_out <= 1'b0;
            err_q     <= 1'b0;
            rem_q     <= '0;
            neg_q     <= 1'b0;
            cout_q    <= 1'b0;
            ov_q      <= 1'b0;
            it_q      <= '0;
            case (OP_sel)
              OP_MUL: begin
                a_q   <= A_in;
                p_q   <= {{WIDTH{1'b0}}, B_in};
                state <= ST_MUL;
              end
              OP_DIV: begin
                if (B_in != '0) begin
                  b_q   <= B_in;
                  q_q   <= A_in;
                  r_q   <= '0;
                  state <= ST_DIV;
                end else begin
                  err_q     <= 1'b1;
                  res_q     <= '0;
                  conv_load <= 1'b1;
                  state     <= ST_CONV;
                end
              end
              default: begin
                res_q     <= (2*WIDTH)'(s_res);
                cout_q    <= s_cout;
                ov_q      <= s_ov;
                neg_q     <= s_neg;
                conv_load <= 1'b1;
                state     <= ST_CONV;
              end
            endcase
          end
        end
        ST_MUL: begin
          p_q  <= p_next;
          it_q <= it_q + 1'b1;
          if (it_q == IT_W'(WIDTH - 1)) begin
            res_q     <= p_next;
            conv_load <= 1'b1;
            state     <= ST_CONV;
          end
        end
        ST_DIV: begin
          r_q  <= r_next;
          q_q  <= q_next;
          it_q <= it_q + 1'b1;
          if (it_q == IT_W'(WIDTH - 1)) begin
            res_q     <= {{WIDTH{1'b0}}, q_next};
            rem_q     <= r_next;
            conv_load <= 1'b1;
            state     <= ST_CONV;
          end
        end
        ST_CONV: begin
          conv_load <= 1'b0;
          if (dab_busy && dab_done) begin
            Done_out   <= 1'b1;
            Result_out <= res_q;
            Rem_out    <= rem_q;
            Cout       <= cout_q;
            OV         <= ov_q;
            Z          <= (res_q == '0);
            ERR        <= err_q;
            Neg_out    <= neg_q;
            state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          Done_out  <= 1'b0;
          Ready_out <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_seq_nbits.sv
// Self-checking bench for ula_seq_nbits (WIDTH=8, DIGITS=5).
module tb_ula_seq_nbits;

  localparam int W = 8;
  localparam int D = 5;

  logic           CLK = 1'b0;
  logic           RST;
  logic [W-1:0]   A_in, B_in;
  logic           Cin;
  logic [2:0]     OP_sel;
  logic           Start_in;
  logic           Ready_out, Done_out;
  logic [2*W-1:0] Result_out;
  logic [W-1:0]   Rem_out;
  logic           Cout, OV, Z, ERR, Neg_out;
  logic [4*D-1:0] BCD_out;

  always #5 CLK = ~CLK;

  ula_seq_nbits #(.WIDTH(W), .DIGITS(D)) dut (
    .CLK(CLK), .RST(RST), .A_in(A_in), .B_in(B_in), .Cin(Cin),
    .OP_sel(OP_sel), .Start_in(Start_in), .Ready_out(Ready_out),
    .Done_out(Done_out), .Result_out(Result_out), .Rem_out(Rem_out),
    .Cout(Cout), .OV(OV), .Z(Z), .ERR(ERR), .Neg_out(Neg_out),
    .BCD_out(BCD_out)
  );

  typedef struct {
    logic [2*W-1:0] res;
    logic [W-1:0]   rem;
    logic           cout, ov, z, err, neg;
    logic [4*D-1:0] bcd;
    int             lat;
  } exp_t;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  bit   cmp_en = 0;
  bit   pending = 0;
  bit   prev_done = 0;
  exp_t expv, held;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference model written from the arithmetic definition of each opcode.
  function automatic exp_t model(input logic [2:0] op, input int a, input int b, input int cin);
    exp_t e;
    int s, m;
    logic [W-1:0] av, bv, lo;
    av = W'(a); bv = W'(b);
    e.res = '0; e.rem = '0; e.cout = 0; e.ov = 0; e.err = 0; e.neg = 0;
    e.lat = 2 * W;
    case (op)
      3'd0: begin
        s = a + b + cin; e.res = (2*W)'(s % 256); e.cout = (s > 255);
        lo = e.res[W-1:0];
        e.ov = (av[W-1] == bv[W-1]) && (lo[W-1] != av[W-1]);
      end
      3'd1: begin
        s = a - b - cin; e.res = (2*W)'((s + 512) % 256); e.cout = (s < 0);
        lo = e.res[W-1:0];
        e.ov = (av[W-1] != bv[W-1]) && (lo[W-1] != av[W-1]);
        e.neg = lo[W-1];
      end
      3'd2: e.res = (2*W)'(av & bv);
      3'd3: e.res = (2*W)'(av | bv);
      3'd4: e.res = (2*W)'(av ^ bv);
      3'd5: begin e.res = (2*W)'(a * b); e.lat = 3 * W; end
      3'd6: begin
        if (b == 0) e.err = 1;
        else begin
          e.res = (2*W)'(a / b); e.rem = W'(a % b); e.lat = 3 * W;
        end
      end
      default: e.res = '0;
    endcase
    e.z = (e.res == 0);
    m = e.neg ? (256 - int'(e.res)) : int'(e.res);
    for (int i = 0; i < D; i++) begin
      e.bcd[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return e;
  endfunction

  task automatic cmp_outputs(input string tag, input exp_t e);
    chk({tag, "_result"}, 32'(Result_out), 32'(e.res));
    chk({tag, "_rem"},    32'(Rem_out),    32'(e.rem));
    chk({tag, "_cout"},   32'(Cout),       32'(e.cout));
    chk({tag, "_ov"},     32'(OV),         32'(e.ov));
    chk({tag, "_z"},      32'(Z),          32'(e.z));
    chk({tag, "_err"},    32'(ERR),        32'(e.err));
    chk({tag, "_neg"},    32'(Neg_out),    32'(e.neg));
    chk({tag, "_bcd"},    32'(BCD_out),    32'(e.bcd));
  endtask

  // Single compare process: full check on Done_out, hold check otherwise.
  always @(negedge CLK) begin
    if (cmp_en && !RST) begin
      if (Done_out) begin
        chk("done_expected", 32'(pending), 32'd1);
        chk("done_latency", 32'(cyc - acc_cyc), 32'(expv.lat));
        chk("ready_in_done", 32'(Ready_out), 32'd0);
        chk("done_one_cycle", 32'(prev_done), 32'd0);
        cmp_outputs("done", expv);
        held = expv;
        pending = 0;
      end else begin
        cmp_outputs("hold", held);
      end
      prev_done = Done_out;
    end
  end

  task automatic start_op(input logic [2:0] op, input int a, input int b, input int cin);
    int n;
    n = 0;
    while (!Ready_out && n < 200) begin @(negedge CLK); n++; end
    if (!Ready_out) chk("ready_timeout", 32'(Ready_out), 32'd1);
    A_in = W'(a); B_in = W'(b); Cin = cin[0]; OP_sel = op; Start_in = 1'b1;
    expv = model(op, a, b, cin);
    acc_cyc = cyc + 1;
    pending = 1;
    @(negedge CLK);
    Start_in = 1'b0;
    A_in = W'($urandom); B_in = W'($urandom); Cin = 1'($urandom);
    OP_sel = 3'($urandom);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!Done_out && n < 200) begin @(negedge CLK); n++; end
    if (!Done_out) chk("done_timeout", 32'(Done_out), 32'd1);
  endtask

  task automatic run(input logic [2:0] op, input int a, input int b, input int cin);
    start_op(op, a, b, cin);
    wait_done();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ready"}, 32'(Ready_out), 32'd1);
    chk({tag, "_done"},  32'(Done_out),  32'd0);
    chk({tag, "_result"}, 32'(Result_out), 32'd0);
    chk({tag, "_rem"},   32'(Rem_out), 32'd0);
    chk({tag, "_bcd"},   32'(BCD_out), 32'd0);
    chk({tag, "_flags"}, 32'({Cout, OV, Z, ERR, Neg_out}), 32'd0);
  endtask

  initial begin
    RST = 1'b1; A_in = '0; B_in = '0; Cin = 1'b0; OP_sel = '0; Start_in = 1'b0;
    held = model(3'd2, 0, 0, 0);
    held.z = 0;
    repeat (3) @(negedge CLK);
    chk_reset_state("reset");
    RST = 1'b0;
    cmp_en = 1;

    // ADD with carry-out
    run(3'd0, 200, 100, 1);
    chk("add_lit_result", 32'(Result_out), 32'h002D);
    chk("add_lit_bcd", 32'(BCD_out), 32'h00045);
    chk("add_lit_cout", 32'(Cout), 32'd1);
    chk("add_lit_latency", 32'(cyc - acc_cyc), 32'd16);
    run(3'd0, 100, 100, 0);   // signed overflow on ADD

    // SUB negative and SUB overflow
    run(3'd1, 3, 5, 0);
    chk("sub_lit_result", 32'(Result_out), 32'h00FE);
    chk("sub_lit_neg", 32'(Neg_out), 32'd1);
    chk("sub_lit_bcd", 32'(BCD_out), 32'h00002);
    run(3'd1, 127, 255, 0);
    chk("sub_ov_lit_result", 32'(Result_out), 32'h0080);
    chk("sub_ov_lit_ov", 32'(OV), 32'd1);

    // MUL with a Start_in pulse mid-operation and in the DONE cycle
    start_op(3'd5, 255, 255, 0);
    repeat (5) @(negedge CLK);
    OP_sel = 3'd0; A_in = 8'd1; B_in = 8'd1; Start_in = 1'b1;
    @(negedge CLK);
    Start_in = 1'b0;
    wait_done();
    chk("mul_lit_result", 32'(Result_out), 32'hFE01);
    chk("mul_lit_bcd", 32'(BCD_out), 32'h65025);
    chk("mul_lit_latency", 32'(cyc - acc_cyc), 32'd24);
    OP_sel = 3'd0; A_in = 8'd9; B_in = 8'd9; Start_in = 1'b1;
    @(negedge CLK);
    Start_in = 1'b0;
    repeat (40) @(negedge CLK);
    chk("ignored_start_ready", 32'(Ready_out), 32'd1);
    chk("ignored_start_result", 32'(Result_out), 32'hFE01);
    run(3'd5, 0, 9, 0);
    chk("mul_zero_lit_z", 32'(Z), 32'd1);

    // DIV normal and divide by zero
    run(3'd6, 200, 7, 0);
    chk("div_lit_result", 32'(Result_out), 32'h001C);
    chk("div_lit_rem", 32'(Rem_out), 32'd4);
    chk("div_lit_bcd", 32'(BCD_out), 32'h00028);
    run(3'd6, 5, 0, 0);
    chk("div0_lit_err", 32'(ERR), 32'd1);
    chk("div0_lit_z", 32'(Z), 32'd1);
    chk("div0_lit_latency", 32'(cyc - acc_cyc), 32'd16);

    // Back-to-back logic ops; ERR must clear after the divide by zero
    run(3'd4, 8'hF0, 8'h3C, 0);
    chk("xor_lit_result", 32'(Result_out), 32'h00CC);
    chk("xor_lit_bcd", 32'(BCD_out), 32'h00204);
    chk("xor_lit_err", 32'(ERR), 32'd0);
    run(3'd2, 8'hF0, 8'h3C, 0);
    chk("and_lit_result", 32'(Result_out), 32'h0030);
    chk("and_lit_bcd", 32'(BCD_out), 32'h00048);
    run(3'd3, 8'h81, 8'h14, 0);
    run(3'd6, 255, 16, 0);

    // Reset during DIV iteration
    start_op(3'd6, 200, 7, 0);
    repeat (3) @(negedge CLK);
    cmp_en = 0;
    RST = 1'b1;
    @(negedge CLK);
    chk_reset_state("rst_mid_div");
    RST = 1'b0;
    pending = 0;
    prev_done = 0;
    held = model(3'd2, 0, 0, 0);
    held.z = 0;
    cmp_en = 1;
    run(3'd0, 1, 2, 0);
    chk("after_rst_lit_result", 32'(Result_out), 32'h0003);
    repeat (3) @(negedge CLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
